// File: rtl/mem_stage_pkg.sv
// Shared definitions for the sized MEM stage: access-size codes, FSM states and
// helpers that turn an access size into byte / bit counts.
package mem_stage_pkg;

    // Access size encodings carried on m_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // INIT clears the RAM after reset, RUN services requests
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Number of bytes touched by an access of the given size
    function automatic int unsigned size_bytes(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

    // Width of the loaded field before extension, clamped to the datapath width
    // so an illegal double access on a 32-bit build never indexes past the word.
    function automatic int unsigned ext_bits(input logic [1:0] size, input int unsigned xlen);
        int unsigned bits;
        bits = 32'd8 << size;
        if (bits > xlen) begin
            bits = xlen;
        end
        return bits;
    endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// Load lane extraction: moves the addressed byte/half/word/double of a memory
// word down to bit 0 and sign- or zero-extends it to the full datapath width.
module mem_lane_extract
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0]              i_word,
    input  logic [$clog2(XLEN/8)-1:0]    i_off,
    input  logic [1:0]                   i_size,
    input  logic                         i_unsigned,
    output logic [XLEN-1:0]              o_data
);

    localparam int unsigned LW = $clog2(XLEN);

    logic [XLEN-1:0] w_shifted;
    logic [LW-1:0]   w_msb;
    logic            w_sign;

    // Shift the addressed lane to bit 0, then fill everything above its MSB
    always_comb begin
        w_shifted = i_word >> {i_off, 3'b000};
        w_msb     = LW'(ext_bits(i_size, XLEN) - 32'd1);
        w_sign    = ~i_unsigned & w_shifted[w_msb];
        o_data    = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            o_data[i] = (LW'(i) <= w_msb) ? w_shifted[i] : w_sign;
        end
    end

endmodule

// File: rtl/mem_stage_sized.sv
// Pipeline MEM stage with parametrised data RAM: sized loads with sign/zero
// extension, byte-enable stores, access-fault detection, registered branch
// resolution, and a post-reset sequencer that zeroes the RAM while m_busy
// holds the pipeline.
module mem_stage_sized
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned PC_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_branch,
    input  logic              m_zero,
    input  logic [XLEN-1:0]   m_addr,
    input  logic              m_memrd,
    input  logic              m_memwr,
    input  logic [1:0]        m_size,
    input  logic              m_unsigned,
    input  logic [XLEN-1:0]   m_write_data,
    input  logic [PC_W-1:0]   m_pc_in,
    output logic [PC_W-1:0]   m_pc_out,
    output logic              m_pcsrc,
    output logic [XLEN-1:0]   m_read_data,
    output logic              m_fault,
    output logic              m_busy
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned BL  = $clog2(NB);
    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned TOP = BL + IW;
    localparam int unsigned EW  = BL + 1;

    // FSM and clear sequencer
    state_e          r_state;
    state_e          w_state_next;
    logic [IW-1:0]   r_clr_idx;
    logic            w_run;

    // Data RAM, one XLEN-wide word per index
    logic [XLEN-1:0] r_mem [DEPTH];

    // Address decode
    logic [IW-1:0]   w_idx;
    logic [BL-1:0]   w_off;
    logic [BL-1:0]   w_amask;
    logic [EW-1:0]   w_end;
    logic            w_oor;
    logic            w_mis;
    logic            w_ill;
    logic            w_req;
    logic            w_fault;
    logic            w_st_we;
    logic            w_ld;

    // Store / load datapath
    logic [NB-1:0]   w_be;
    logic [XLEN-1:0] w_wdata_sh;
    logic [XLEN-1:0] w_word;
    logic [XLEN-1:0] w_ext;

    // Registered outputs
    logic [PC_W-1:0] r_pc_out;
    logic            r_pcsrc;
    logic [XLEN-1:0] r_read_data;
    logic            r_fault;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave INIT once the last word has been cleared
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_clr_idx == IW'(DEPTH - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    // FSM outputs: stall upstream for the whole clear
    always_comb begin
        m_busy = (r_state == ST_INIT);
        w_run  = (r_state == ST_RUN);
    end

    // Clear index walks every word once during INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_idx <= '0;
        end else if (r_state == ST_INIT) begin
            r_clr_idx <= r_clr_idx + IW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Address decode and fault detection
    // ------------------------------------------------------------------

    assign w_idx = m_addr[BL +: IW];
    assign w_off = m_addr[BL-1:0];

    // Any address bit above the index field means the access misses the RAM
    if (TOP < XLEN) begin : g_range
        assign w_oor = |m_addr[XLEN-1:TOP];
    end else begin : g_full
        assign w_oor = 1'b0;
    end

    // Alignment, size legality and the combined fault condition
    always_comb begin
        w_amask = BL'(size_bytes(m_size) - 32'd1);
        w_mis   = |(w_off & w_amask);
        w_ill   = (XLEN == 32) && (m_size == SZ_D);
        w_req   = m_memrd | m_memwr;
        w_fault = w_req & (w_oor | w_mis | w_ill | (m_memrd & m_memwr));
        w_st_we = w_run & m_memwr & ~w_fault;
        w_ld    = w_run & m_memrd & ~w_fault;
    end

    // ------------------------------------------------------------------
    // Store path
    // ------------------------------------------------------------------

    // Byte enables span [offset, offset + size) within the word
    always_comb begin
        w_end = {1'b0, w_off} + EW'(size_bytes(m_size));
        w_be  = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if ((EW'(b) >= {1'b0, w_off}) && (EW'(b) < w_end)) begin
                w_be[b] = 1'b1;
            end
        end
    end

    assign w_wdata_sh = m_write_data << {w_off, 3'b000};

    // RAM write: zero fill during INIT, byte-enabled stores in RUN
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_st_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------

    // Asynchronous read so a load right after a store sees the committed data
    assign w_word = r_mem[w_idx];

    mem_lane_extract #(
        .XLEN (XLEN)
    ) u_lane_extract (
        .i_word     (w_word),
        .i_off      (w_off),
        .i_size     (m_size),
        .i_unsigned (m_unsigned),
        .o_data     (w_ext)
    );

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------

    // Branch forwarding, load result and fault flag; all held at 0 during INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_out    <= '0;
            r_pcsrc     <= 1'b0;
            r_read_data <= '0;
            r_fault     <= 1'b0;
        end else if (!w_run) begin
            r_pc_out    <= '0;
            r_pcsrc     <= 1'b0;
            r_read_data <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_pc_out <= m_pc_in;
            r_pcsrc  <= m_branch & m_zero;
            r_fault  <= w_fault;
            // Faults and stores clear the load result; idle cycles hold it
            if (w_fault || w_st_we) begin
                r_read_data <= '0;
            end else if (w_ld) begin
                r_read_data <= w_ext;
            end
        end
    end

    assign m_pc_out    = r_pc_out;
    assign m_pcsrc     = r_pcsrc;
    assign m_read_data = r_read_data;
    assign m_fault     = r_fault;

endmodule

// File: tb/tb_mem_stage_sized.sv
// Bench for mem_stage_sized: byte-array reference model, per-cycle compare at
// the falling edge, directed scenarios with literal expectations, random traffic.
module tb_mem_stage_sized;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned PC_W  = 12;
    localparam int unsigned NBYTE = DEPTH * 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              m_branch;
    logic              m_zero;
    logic [XLEN-1:0]   m_addr;
    logic              m_memrd;
    logic              m_memwr;
    logic [1:0]        m_size;
    logic              m_unsigned;
    logic [XLEN-1:0]   m_write_data;
    logic [PC_W-1:0]   m_pc_in;
    logic [PC_W-1:0]   m_pc_out;
    logic              m_pcsrc;
    logic [XLEN-1:0]   m_read_data;
    logic              m_fault;
    logic              m_busy;

    mem_stage_sized #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_branch     (m_branch),
        .m_zero       (m_zero),
        .m_addr       (m_addr),
        .m_memrd      (m_memrd),
        .m_memwr      (m_memwr),
        .m_size       (m_size),
        .m_unsigned   (m_unsigned),
        .m_write_data (m_write_data),
        .m_pc_in      (m_pc_in),
        .m_pc_out     (m_pc_out),
        .m_pcsrc      (m_pcsrc),
        .m_read_data  (m_read_data),
        .m_fault      (m_fault),
        .m_busy       (m_busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]        mem [NBYTE];
    int                busy_left;
    int                busy_next;
    logic [PC_W-1:0]   exp_pc, pend_pc;
    logic              exp_pcsrc, pend_pcsrc;
    logic [XLEN-1:0]   exp_rd, pend_rd;
    logic              exp_fault, pend_fault;

    int                n_checks = 0;
    int                n_err = 0;
    bit                chk_en = 1'b0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    // Literal check on both the DUT and the model
    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] model,
                       input logic [63:0] want);
        cmp(name, act, want);
        cmp({name, "_model"}, model, want);
    endtask

    // Per-cycle compare, away from the rising edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("pc_out", 64'(m_pc_out), 64'(exp_pc));
            cmp("pcsrc", 64'(m_pcsrc), 64'(exp_pcsrc));
            cmp("read_data", m_read_data, exp_rd);
            cmp("fault", 64'(m_fault), 64'(exp_fault));
            cmp("busy", 64'(m_busy), 64'(busy_left > 0));
        end
    end

    // What the stage must present after the coming rising edge
    task automatic model_eval();
        logic [63:0] a;
        logic [63:0] v;
        int          nb;
        int          off;
        bit          flt;
        if (!rst_n) begin
            pend_pc = '0; pend_pcsrc = 1'b0; pend_rd = '0; pend_fault = 1'b0;
            busy_next = DEPTH;
        end else if (busy_left > 0) begin
            pend_pc = '0; pend_pcsrc = 1'b0; pend_rd = '0; pend_fault = 1'b0;
            busy_next = busy_left - 1;
        end else begin
            busy_next  = 0;
            pend_pc    = m_pc_in;
            pend_pcsrc = m_branch & m_zero;
            pend_rd    = exp_rd;
            pend_fault = 1'b0;
            a   = m_addr;
            nb  = 1 << m_size;
            off = int'(a % 8);
            flt = (m_memrd || m_memwr) &&
                  ((a >= 64'(NBYTE)) || ((off % nb) != 0) || (m_memrd && m_memwr));
            if (flt) begin
                pend_rd    = '0;
                pend_fault = 1'b1;
            end else if (m_memwr) begin
                for (int k = 0; k < nb; k++) mem[int'(a) + k] = m_write_data[8*k +: 8];
                pend_rd = '0;
            end else if (m_memrd) begin
                v = '0;
                for (int k = 0; k < nb; k++) v = v | (64'(mem[int'(a) + k]) << (8 * k));
                if (!m_unsigned && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
                pend_rd = v;
            end
        end
    endtask

    task automatic cyc();
        model_eval();
        @(posedge clk);
        #1;
        exp_pc = pend_pc; exp_pcsrc = pend_pcsrc; exp_rd = pend_rd; exp_fault = pend_fault;
        busy_left = busy_next;
    endtask

    task automatic idle();
        m_branch = 1'b0; m_zero = 1'b0; m_pc_in = '0;
        m_memrd = 1'b0; m_memwr = 1'b0; m_size = 2'd0; m_unsigned = 1'b0;
        m_addr = '0; m_write_data = '0;
    endtask

    task automatic acc(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] data);
        m_memrd = rd; m_memwr = wr; m_size = sz; m_unsigned = uns;
        m_addr = addr; m_write_data = data;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        busy_left = DEPTH;
        exp_pc = '0; exp_pcsrc = 1'b0; exp_rd = '0; exp_fault = 1'b0;
        for (int i = 0; i < NBYTE; i++) mem[i] = 8'h00;
        #1;
        lit("rst_busy", 64'(m_busy), 64'(busy_left > 0), 64'd1);
        lit("rst_rd", m_read_data, exp_rd, 64'd0);
        repeat (n) cyc();
        rst_n = 1'b1;
    endtask

    int busy_cnt;

    initial begin
        logic [31:0] r;
        logic [63:0] addr;
        int          sz;
        int          op;

        idle();
        #1;
        chk_en = 1'b1;
        apply_reset(3);

        // Store during busy must be dropped; count the busy window
        acc(1'b0, 1'b1, 2'd3, 1'b0, 64'h10, 64'hDEAD_BEEF_0BAD_F00D);
        cyc();
        busy_cnt = 1;
        idle();
        while (m_busy && busy_cnt < 3000) begin
            cyc();
            busy_cnt++;
        end
        cmp("busy_len", 64'(busy_cnt), 64'd1024);
        acc(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, '0); cyc();
        lit("ld_after_clear", m_read_data, exp_rd, 64'd0);

        // Sized stores and loads
        acc(1'b0, 1'b1, 2'd3, 1'b0, 64'h40, 64'h1122334455667788); cyc();
        lit("st_d_rd0", m_read_data, exp_rd, 64'd0);
        acc(1'b1, 1'b0, 2'd0, 1'b0, 64'h47, '0); cyc();
        lit("ldb_47", m_read_data, exp_rd, 64'h11);
        acc(1'b1, 1'b0, 2'd1, 1'b0, 64'h46, '0); cyc();
        lit("ldh_46", m_read_data, exp_rd, 64'h1122);
        acc(1'b0, 1'b1, 2'd0, 1'b0, 64'h43, 64'hAB); cyc();
        lit("stb_43_rd0", m_read_data, exp_rd, 64'd0);
        acc(1'b1, 1'b0, 2'd3, 1'b0, 64'h40, '0); cyc();
        lit("ldd_40", m_read_data, exp_rd, 64'h11223344AB667788);
        idle(); cyc();
        lit("idle_hold", m_read_data, exp_rd, 64'h11223344AB667788);
        acc(1'b0, 1'b1, 2'd0, 1'b0, 64'h41, 64'h80); cyc();
        acc(1'b1, 1'b0, 2'd0, 1'b0, 64'h41, '0); cyc();
        lit("ldb_s_41", m_read_data, exp_rd, 64'hFFFFFFFFFFFFFF80);
        acc(1'b1, 1'b0, 2'd0, 1'b1, 64'h41, '0); cyc();
        lit("ldb_u_41", m_read_data, exp_rd, 64'h80);

        // Faults
        acc(1'b1, 1'b0, 2'd2, 1'b0, 64'h42, '0); cyc();
        lit("misal_fault", 64'(m_fault), 64'(exp_fault), 64'd1);
        lit("misal_rd", m_read_data, exp_rd, 64'd0);
        acc(1'b0, 1'b1, 2'd3, 1'b0, 64'h2000, 64'hFFFFFFFFFFFFFFFF); cyc();
        lit("oor_fault", 64'(m_fault), 64'(exp_fault), 64'd1);
        acc(1'b1, 1'b0, 2'd3, 1'b0, 64'h0, '0); cyc();
        lit("oor_nowrite", m_read_data, exp_rd, 64'd0);
        lit("fault_clear", 64'(m_fault), 64'(exp_fault), 64'd0);
        acc(1'b1, 1'b1, 2'd3, 1'b0, 64'h40, '0); cyc();
        lit("rdwr_fault", 64'(m_fault), 64'(exp_fault), 64'd1);

        // Branch path, including alongside a faulting access
        idle();
        m_branch = 1'b1; m_zero = 1'b1; m_pc_in = 12'h3A4; cyc();
        lit("pcsrc_1", 64'(m_pcsrc), 64'(exp_pcsrc), 64'd1);
        lit("pc_3a4", 64'(m_pc_out), 64'(exp_pc), 64'h3A4);
        m_zero = 1'b0; cyc();
        lit("pcsrc_0", 64'(m_pcsrc), 64'(exp_pcsrc), 64'd0);
        m_zero = 1'b1; m_pc_in = 12'h155;
        acc(1'b1, 1'b0, 2'd2, 1'b0, 64'h42, '0); cyc();
        lit("pcsrc_flt", 64'(m_pcsrc), 64'(exp_pcsrc), 64'd1);
        lit("pc_flt", 64'(m_pc_out), 64'(exp_pc), 64'h155);
        lit("fault_br", 64'(m_fault), 64'(exp_fault), 64'd1);

        // Random traffic over a small window plus occasional wild addresses
        for (int n = 0; n < 1500; n++) begin
            r = $urandom;
            m_branch = r[0];
            m_zero   = r[1];
            m_pc_in  = r[13:2];
            sz   = int'($urandom_range(0, 3));
            addr = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
            if (r[17:16] != 2'b00) addr = addr & ~64'((1 << sz) - 1);
            if (r[21:18] == 4'd0) addr = {$urandom, $urandom};
            else if (r[21:18] == 4'd1) addr = 64'h2000 + addr;
            op = int'($urandom_range(0, 9));
            acc(op <= 3 || op == 7, op >= 4 && op <= 7, 2'(sz), r[22], addr,
                {$urandom, $urandom});
            cyc();
        end

        // Reset in the middle of INIT restarts the full clear
        idle();
        apply_reset(2);
        repeat (500) cyc();
        apply_reset(2);
        busy_cnt = 0;
        while (m_busy && busy_cnt < 3000) begin
            cyc();
            busy_cnt++;
        end
        cmp("busy_len_restart", 64'(busy_cnt), 64'd1024);
        acc(1'b1, 1'b0, 2'd3, 1'b0, 64'h40, '0); cyc();
        lit("ld_after_reclear", m_read_data, exp_rd, 64'd0);
        idle(); cyc();

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_sized.md
Name: mem_stage_sized

Overview:
- Parametrised successor to the pipeline MEM-stage data memory. Sits between EX/MEM and MEM/WB.
- Adds XLEN/depth parameters, sized and sign/zero-extended loads, byte-enable stores, and a fault flag for misaligned or out-of-range accesses.
- Adds a post-reset RAM-clear sequencer that stalls the pipeline via m_busy.
- Branch resolution (pcsrc) and PC forwarding are registered, as in the existing stage.

Parameters:
- XLEN, 64, data and address width; 32 or 64.
- DEPTH, 1024, memory depth in XLEN-wide words; power of two.
- PC_W, 12, program-counter width.

Ports:
- clk  in  1  rising-edge clock. One clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- m_branch  in  1  instruction is a branch.
- m_zero  in  1  ALU zero flag.
- m_addr  in  XLEN  byte address (ALU result).
- m_memrd  in  1  load request.
- m_memwr  in  1  store request.
- m_size  in  2  access size: 0=byte, 1=half, 2=word, 3=double.
- m_unsigned  in  1  load is zero-extended when 1, sign-extended when 0.
- m_write_data  in  XLEN  store data, taken from the low bits.
- m_pc_in  in  PC_W  branch target PC.
- m_pc_out  out  PC_W  registered m_pc_in.
- m_pcsrc  out  1  registered (m_branch & m_zero).
- m_read_data  out  XLEN  registered load result.
- m_fault  out  1  registered access-fault flag.
- m_busy  out  1  RAM clear in progress; upstream must stall.

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0: m_pc_out=0, m_pcsrc=0, m_read_data=0, m_fault=0, state=INIT, clear index=0, m_busy=1.
  - RAM contents are not reset directly.
- FSM states are INIT and RUN.
  - INIT: each clock writes 0 to word[idx], then idx increments. When idx=DEPTH-1 has been written, next state is RUN.
  - INIT lasts exactly DEPTH cycles after rst_n rises.
  - m_busy=1 throughout INIT and 0 in RUN. It is driven combinationally from state.
  - Reset asserted mid-INIT restarts the clear from idx 0.
  - During INIT, all requests are ignored, m_pcsrc=0, m_fault=0, and m_read_data holds 0.
- Address decode (RUN), with BL=log2(XLEN/8):
  - word index = m_addr[BL +: log2(DEPTH)]
  - byte offset = m_addr[BL-1:0]
  - Out of range: any m_addr bit above the index field is nonzero.
  - Misaligned: offset not a multiple of (1<<m_size).
  - Illegal size: m_size=3 when XLEN=32.
- Fault condition: a request (m_memrd|m_memwr) that is out of range, misaligned, illegal size, or has m_memrd and m_memwr both high.
  - On a fault: no RAM write, m_read_data<=0, m_fault<=1 the next cycle.
  - Otherwise m_fault<=0 every cycle.
- Store (m_memwr=1, no fault):
  - Committed at the rising edge.
  - Byte enables cover bytes [offset, offset+(1<<m_size)-1] only, filled from m_write_data low bytes. Other bytes are unchanged.
  - m_read_data<=0.
- Load (m_memrd=1, no fault):
  - m_read_data is valid 1 cycle after the request edge.
  - Value is the selected bytes, shifted to bit 0, then sign- or zero-extended per m_unsigned.
  - A load in the cycle after a store to the same word returns the new data; no bypass is needed.
- Idle cycle (no request): m_read_data holds its previous value.
- Branch path (RUN): every cycle, m_pc_out<=m_pc_in and m_pcsrc<=m_branch&m_zero. Unaffected by faults.
- Little-endian byte order.

Decomposition:
- Package mem_stage_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - FSM state enum ST_INIT/ST_RUN
  - helper function for extension-width selection
- One sub-module, mem_lane_extract: combinational byte/half/word select plus sign/zero extension, parametrised by XLEN. Everything else stays in the top level.

Test Plan:
- Reset, then release rst_n -> m_busy=1 for exactly DEPTH(1024) cycles, then 0. Load of 0x10 then returns 0. A store issued during busy is ignored; reading that address afterwards returns 0.
- Store double 0x1122334455667788 @0x40, then load byte signed @0x47 -> 0x0000000000000011. Load half @0x46 -> 0x1122. Load byte signed after byte store 0x80 @0x41 -> 0xFFFFFFFFFFFFFF80; with m_unsigned=1 -> 0x80.
- Store byte 0xAB @0x43 over the stored double -> the next double load @0x40 returns 0x11223344AB667788. m_read_data is 0 in the cycle after the store.
- Load word @0x42 -> m_fault=1, m_read_data=0. Store @0x2000 (DEPTH=1024, XLEN=64) -> m_fault=1 and memory unchanged. m_memrd=m_memwr=1 -> m_fault=1.
- m_branch=1, m_zero=1, m_pc_in=0x3A4 -> next cycle m_pcsrc=1, m_pc_out=0x3A4. With m_zero=0 -> m_pcsrc=0. Repeat alongside a faulting access -> branch outputs are unaffected.
- Assert rst_n=0 at INIT cycle 500 for 2 cycles, then release -> all outputs 0 during reset, and m_busy stays high a full 1024 cycles after release.
